pipe_sched: RTL and testbench

- Issue scheduler that sequences the fetch→decode→execute handshakes around the instruction-decode stage.
- Drives the decode stage's fetched-request input and decoded-acknowledge input.
- Keeps an in-order scoreboard of destination registers for in-flight instructions. Holds decode issue on RAW hazards or a full scoreboard.
- Flushes all in-flight work on a write-back redirect.

---
 rtl/pipe_sched.sv | 152 +++++++++++++++
 tb/tb_pipe_sched.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_sched.sv
// Issue scheduler around the decode stage: IF/ID/EX handshakes, in-order
// destination-register scoreboard for RAW/full holds, and redirect flush.
//
// state    | meaning
// IDLE     | waiting for IF; forwards a fetched instruction to decode
// WAIT_DEC | decode output pending; issue unless hazard or scoreboard full
// FLUSH    | one cycle after redirect; drain any decoded inst, no issue
module pipe_sched #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_if_valid,
    output logic                     o_if_ack,
    output logic                     o_id_fetched_req,
    input  logic                     i_id_decoded_req,
    output logic                     o_id_decoded_ack,
    input  logic                     i_id_rs1_ren,
    input  logic [4:0]               i_id_rs1,
    input  logic                     i_id_rs2_ren,
    input  logic [4:0]               i_id_rs2,
    input  logic [4:0]               i_id_rd,
    output logic                     o_ex_issue,
    input  logic                     i_wb_retire,
    input  logic                     i_wb_redirect,
    output logic                     o_flush,
    output logic [$clog2(DEPTH):0]   o_sb_count,
    output logic [CNT_W-1:0]         o_stall_cnt,
    output logic                     o_err
);

    localparam int PW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT_DEC, FLUSH} state_t;

    state_t           state, state_nxt;
    logic [DEPTH-1:0] sb_valid;
    logic [4:0]       sb_rd [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [PW:0]      count;
    logic [CNT_W-1:0] stall_cnt;
    logic             err;

    logic pop, redirect, full, hazard;
    logic if_ack, fetched_req, decoded_ack, issue, stall;

    assign pop      = i_wb_retire && (count != '0);
    assign redirect = pop && i_wb_redirect;
    assign full     = (count == (PW+1)'(DEPTH));

    // Compare against pre-pop contents: a retiring entry still blocks this cycle.
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (sb_valid[i] &&
                ((i_id_rs1_ren && (i_id_rs1 != 5'd0) && (sb_rd[i] == i_id_rs1)) ||
                 (i_id_rs2_ren && (i_id_rs2 != 5'd0) && (sb_rd[i] == i_id_rs2))))
                hazard = 1'b1;
        end
    end

    always_comb begin
        state_nxt   = state;
        if_ack      = 1'b0;
        fetched_req = 1'b0;
        decoded_ack = 1'b0;
        issue       = 1'b0;
        stall       = 1'b0;
        case (state)
            IDLE: begin
                if (redirect) begin
                    state_nxt = FLUSH;
                end else if (i_if_valid) begin
                    if_ack      = 1'b1;
                    fetched_req = 1'b1;
                    state_nxt   = WAIT_DEC;
                end
            end
            WAIT_DEC: begin
                if (redirect) begin
                    state_nxt = FLUSH;
                end else if (i_id_decoded_req) begin
                    if (hazard || full) begin
                        stall = 1'b1;
                    end else begin
                        decoded_ack = 1'b1;
                        issue       = 1'b1;
                        state_nxt   = IDLE;
                    end
                end
            end
            FLUSH: begin
                decoded_ack = i_id_decoded_req;
                state_nxt   = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Input-driven handshakes are gated so every output reads 0 while in reset.
    assign o_if_ack         = if_ack && rst;
    assign o_id_fetched_req = fetched_req && rst;
    assign o_id_decoded_ack = decoded_ack && rst;
    assign o_ex_issue       = issue && rst;
    assign o_flush          = (state == FLUSH);
    assign o_sb_count       = count;
    assign o_stall_cnt      = stall_cnt;
    assign o_err            = err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            sb_valid  <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            stall_cnt <= '0;
            err       <= 1'b0;
            for (int i = 0; i < DEPTH; i++) sb_rd[i] <= 5'd0;
        end else begin
            state <= state_nxt;
            if (i_wb_retire && (count == '0))
                err <= 1'b1;
            if (stall && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;
            if (redirect) begin
                sb_valid <= '0;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                count    <= '0;
            end else begin
                // Push and pop never share a slot: push needs not-full, pop needs not-empty.
                if (issue) begin
                    sb_valid[wr_ptr] <= (i_id_rd != 5'd0);
                    sb_rd[wr_ptr]    <= i_id_rd;
                    wr_ptr           <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    sb_valid[rd_ptr] <= 1'b0;
                    rd_ptr           <= rd_ptr + 1'b1;
                end
                case ({issue, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pipe_sched.sv
// Self-checking bench for pipe_sched: directed handshake sequences with an
// expected-issue queue compared whenever the DUT pulses o_ex_issue.
module tb_pipe_sched;

    localparam int DEPTH = 4;
    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             i_if_valid, i_id_decoded_req;
    logic             i_id_rs1_ren, i_id_rs2_ren;
    logic [4:0]       i_id_rs1, i_id_rs2, i_id_rd;
    logic             i_wb_retire, i_wb_redirect;
    logic             o_if_ack, o_id_fetched_req, o_id_decoded_ack, o_ex_issue, o_flush, o_err;
    logic [2:0]       o_sb_count;
    logic [CNT_W-1:0] o_stall_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    logic [4:0] exp_q [$];

    pipe_sched #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .i_if_valid(i_if_valid), .o_if_ack(o_if_ack),
        .o_id_fetched_req(o_id_fetched_req),
        .i_id_decoded_req(i_id_decoded_req), .o_id_decoded_ack(o_id_decoded_ack),
        .i_id_rs1_ren(i_id_rs1_ren), .i_id_rs1(i_id_rs1),
        .i_id_rs2_ren(i_id_rs2_ren), .i_id_rs2(i_id_rs2),
        .i_id_rd(i_id_rd), .o_ex_issue(o_ex_issue),
        .i_wb_retire(i_wb_retire), .i_wb_redirect(i_wb_redirect),
        .o_flush(o_flush), .o_sb_count(o_sb_count),
        .o_stall_cnt(o_stall_cnt), .o_err(o_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every issue pulse must match the next expected rd.
    always @(negedge clk) begin
        if (rst && o_ex_issue) begin
            if (exp_q.size() == 0) check("issue_spurious", 32'd1, 32'd0);
            else                   check("issue_rd", 32'(i_id_rd), 32'(exp_q.pop_front()));
        end
    end

    task automatic tick;
        @(posedge clk); #1;
    endtask

    task automatic fetch;
        tick;
        i_if_valid = 1'b1;
        @(negedge clk);
        check("fetch_req", {o_id_fetched_req, o_if_ack}, 2'b11);
        tick;
        i_if_valid = 1'b0;
    endtask

    task automatic set_dec(input logic [4:0] rd, input logic [4:0] rs1, input logic r1,
                           input logic [4:0] rs2, input logic r2);
        i_id_decoded_req = 1'b1;
        i_id_rd = rd; i_id_rs1 = rs1; i_id_rs1_ren = r1; i_id_rs2 = rs2; i_id_rs2_ren = r2;
    endtask

    task automatic issue_now(input logic [4:0] rd, input logic [4:0] rs1, input logic r1,
                             input logic [4:0] rs2, input logic r2);
        fetch;
        set_dec(rd, rs1, r1, rs2, r2);
        exp_q.push_back(rd);
        @(negedge clk);
        check("issue_ack", {o_id_decoded_ack, o_ex_issue}, 2'b11);
        tick;
        i_id_decoded_req = 1'b0;
    endtask

    task automatic retire_n(input int n);
        tick;
        i_wb_retire = 1'b1;
        repeat (n) tick;
        i_wb_retire = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        i_if_valid = 0; i_id_decoded_req = 0; i_id_rs1_ren = 0; i_id_rs2_ren = 0;
        i_id_rs1 = 0; i_id_rs2 = 0; i_id_rd = 0; i_wb_retire = 0; i_wb_redirect = 0;
        #3;
        check("reset_outs", {o_if_ack, o_id_fetched_req, o_id_decoded_ack, o_ex_issue,
                             o_flush, o_sb_count, o_stall_cnt, o_err}, 12'd0);
        @(posedge clk); #1 rst = 1'b1;

        // No hazard: fetch cycle N, issue cycle N+1
        issue_now(5'd5, 5'd1, 1'b1, 5'd0, 1'b0);
        @(negedge clk);
        check("nohaz_count", 32'(o_sb_count), 32'd1);

        // RAW on rd=5: three stall cycles, then retire cycle still stalls
        fetch;
        set_dec(5'd6, 5'd5, 1'b1, 5'd0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            if (k > 0) tick;
            @(negedge clk);
            check("raw_stall", 32'(o_id_decoded_ack), 32'd0);
        end
        tick;
        i_wb_retire = 1'b1;
        @(negedge clk);
        check("raw_retire_stall", {o_id_decoded_ack, o_ex_issue}, 2'b00);
        check("raw_stall_cnt3", 32'(o_stall_cnt), 32'd3);
        tick;
        i_wb_retire = 1'b0;
        exp_q.push_back(5'd6);
        @(negedge clk);
        check("raw_issue", {o_id_decoded_ack, o_ex_issue}, 2'b11);
        check("raw_stall_cnt4", 32'(o_stall_cnt), 32'd4);
        tick;
        i_id_decoded_req = 1'b0;
        @(negedge clk);
        check("raw_count", 32'(o_sb_count), 32'd1);

        // x0 / rd=0 never block
        retire_n(1);
        issue_now(5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        issue_now(5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
        @(negedge clk);
        check("x0_count", 32'(o_sb_count), 32'd2);
        retire_n(2);
        @(negedge clk);
        check("drain_count", 32'(o_sb_count), 32'd0);

        // Full scoreboard: independent fifth inst waits for a retire
        for (int r = 1; r <= 4; r++) issue_now(5'(r), 5'd0, 1'b0, 5'd0, 1'b0);
        @(negedge clk);
        check("full_count", 32'(o_sb_count), 32'd4);
        fetch;
        set_dec(5'd9, 5'd9, 1'b1, 5'd0, 1'b0);
        @(negedge clk);
        check("full_stall1", 32'(o_id_decoded_ack), 32'd0);
        tick;
        @(negedge clk);
        check("full_stall2", 32'(o_id_decoded_ack), 32'd0);
        tick;
        i_wb_retire = 1'b1;
        @(negedge clk);
        check("full_retire_stall", 32'(o_id_decoded_ack), 32'd0);
        tick;
        i_wb_retire = 1'b0;
        exp_q.push_back(5'd9);
        @(negedge clk);
        check("full_issue", {o_id_decoded_ack, o_ex_issue}, 2'b11);
        tick;
        i_id_decoded_req = 1'b0;
        @(negedge clk);
        check("full_count_after", 32'(o_sb_count), 32'd4);
        check("stall_cnt7", 32'(o_stall_cnt), 32'd7);

        // Redirect with count=3 and a decode pending on a hazard
        retire_n(1);
        @(negedge clk);
        check("redir_pre_count", 32'(o_sb_count), 32'd3);
        fetch;
        set_dec(5'd5, 5'd4, 1'b1, 5'd0, 1'b0);
        @(negedge clk);
        check("redir_stall", 32'(o_id_decoded_ack), 32'd0);
        tick;
        i_wb_retire = 1'b1; i_wb_redirect = 1'b1;
        @(negedge clk);
        check("redir_cycle", {o_id_decoded_ack, o_ex_issue, o_flush}, 3'b000);
        tick;
        i_wb_retire = 1'b0; i_wb_redirect = 1'b0;
        @(negedge clk);
        check("flush_pulse", {o_flush, o_id_decoded_ack, o_ex_issue, o_if_ack}, 4'b1100);
        check("flush_count", 32'(o_sb_count), 32'd0);
        tick;
        i_id_decoded_req = 1'b0;
        @(negedge clk);
        check("flush_done", 32'(o_flush), 32'd0);
        check("stall_sat", 32'(o_stall_cnt), 32'd7);
        issue_now(5'd0, 5'd4, 1'b1, 5'd0, 1'b0);

        // Retire on empty sets sticky error
        retire_n(1);
        @(negedge clk);
        check("pre_err", {o_err, o_sb_count}, 4'b0000);
        retire_n(1);
        @(negedge clk);
        check("err_set", 32'(o_err), 32'd1);
        tick; tick;
        @(negedge clk);
        check("err_sticky", {o_err, o_sb_count}, 4'b1000);

        // Async reset while waiting in WAIT_DEC, inputs still active
        fetch;
        i_if_valid = 1'b1;
        @(negedge clk); #2;
        rst = 1'b0;
        #1;
        check("async_rst_outs", {o_if_ack, o_id_fetched_req, o_id_decoded_ack, o_ex_issue,
                                 o_flush, o_sb_count, o_stall_cnt, o_err}, 12'd0);
        i_if_valid = 1'b0;
        tick;
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_idle", {o_if_ack, o_sb_count, o_err}, 5'd0);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
